lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
- Load/store sequencer between the execute stage and the data-memory bus.
- Accepts one decoded memory operation at a time and presents a word-aligned request with byte enables.
- Holds the request until the bus acknowledges, then returns aligned, sign- or zero-extended load data for write-back.
- Stalls the pipeline while an access is outstanding and times out if the bus never responds.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; fixed at 32, byte lanes = 4.
- TIMEOUT_CYC, 16, max cycles in ACCESS without ack before abort; 0 disables the timeout.

Ports:
- clk_in  input  1  clock, rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- req_valid_in  input  1  execute stage presents a memory op.
- req_ready_o  output  1  controller can accept an op.
- is_store_in  input  1  1 = store, 0 = load.
- load_size_in  input  2  00 byte, 01 half, 10 word, 11 treated as word.
- load_unsigned_in  input  1  1 = zero-extend load data.
- addr_in  input  ADDR_W  byte address.
- wdata_in  input  DATA_W  store data, right-justified.
- rd_addr_in  input  5  load destination register.
- bus_req_o  output  1  bus request.
- bus_we_o  output  1  write enable.
- bus_addr_o  output  ADDR_W  {addr[ADDR_W-1:2], 2'b00}.
- bus_be_o  output  4  byte enables.
- bus_wdata_o  output  DATA_W  lane-replicated store data.
- bus_ack_in  input  1  bus completion; one-cycle pulse.
- bus_rdata_in  input  DATA_W  read data, valid with ack.
- stall_o  output  1  pipeline stall.
- wb_valid_o  output  1  load result valid; one-cycle pulse.
- wb_rd_o  output  5  destination register.
- wb_data_o  output  DATA_W  extended load data.
- err_o  output  1  timeout abort; one-cycle pulse.
- misalign_o  output  1  misaligned access trap; one-cycle pulse.

Behaviour:
- Reset: state IDLE, all outputs 0, timeout counter 0. Reset asserted mid-access aborts immediately; no wb_valid_o or err_o is produced for that access.
- FSM states: IDLE, ACCESS, RESP, ERR.
- IDLE
  - req_ready_o=1.
  - On req_valid_in at edge T: register op, address, byte enables and data; go to ACCESS.
  - bus_ack_in is ignored in IDLE.
- ACCESS
  - bus_req_o=1 from T+1.
  - bus_addr_o, bus_we_o, bus_be_o and bus_wdata_o are registered and held stable until ack.
  - Counter increments each cycle.
  - On bus_ack_in at cycle A: a load goes to RESP; a store goes to IDLE.
  - If the counter reaches TIMEOUT_CYC with no ack: go to ERR.
  - Ack in the same cycle as expiry: ack wins.
- RESP: at A+1, wb_valid_o=1 with wb_rd_o and wb_data_o; next state IDLE.
- ERR: err_o=1 for one cycle; no writeback; next state IDLE.
- stall_o is 1 whenever state is not IDLE. req_ready_o is 1 only in IDLE.
- bus_req_o drops in the cycle after ack or expiry.
- Load latency: ack to wb_valid_o is 1 cycle.
- Back-to-back: a new op can be accepted the cycle after return to IDLE.
- Byte enables, with off = addr[1:0]:
  - Byte: 4'b0001 << off.
  - Half: 4'b0011 << {addr[1],1'b0}.
  - Word: 4'b1111.
- Store data:
  - Byte: wdata[7:0] replicated ×4.
  - Half: wdata[15:0] replicated ×2.
  - Word: passed unchanged.
- Load data:
  - Byte: shift bus_rdata_in right by 8×off, take bits [7:0].
  - Half: shift right by 16×addr[1], take bits [15:0].
  - Sign-extend from the MSB of the field unless load_unsigned_in=1, then zero-extend.
  - Word: passed unchanged.
  - Registered at ack.
- Op attributes are latched at acceptance; input changes during ACCESS have no effect.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - Half with addr[0]=1, or word with addr[1:0]!=0, is accepted but issues no bus request.
  - FSM goes to ERR-equivalent handling: misalign_o=1 at T+1 (err_o stays 0); stall_o=1 for that cycle; return to IDLE at T+2.
- Undefined:
  - misalign_o tied 0.
  - Half uses addr[1] only; word ignores addr[1:0].

Test Plan:
- Word load: addr=0x104, ack 3 cycles after bus_req_o rises with rdata=0xDEADBEEF → bus_addr_o=0x104, be=1111; wb_valid_o one cycle after ack with wb_data_o=0xDEADBEEF; stall_o high from T+1 through the wb cycle.
- Signed byte load: addr=0x203, rdata=0x80FFFFFF → be=1000, wb_data_o=0xFFFFFF80. Same access with load_unsigned_in=1 → wb_data_o=0x00000080.
- Half store: addr=0x302, wdata=0x1234ABCD → bus_we_o=1, be=1100, bus_wdata_o=0xABCDABCD; no wb_valid_o; req_ready_o=1 the cycle after ack.
- Timeout: TIMEOUT_CYC=4, never ack → bus_req_o high 4 cycles; err_o pulses 1 cycle; no wb_valid_o; next op accepted.
- Reset mid-ACCESS: assert rst_in two cycles into ACCESS → all outputs 0 asynchronously; an ack after reset release is ignored.
- With LSU_MISALIGN_TRAP_EN: word load addr=0x106 → bus_req_o never asserts; misalign_o=1 at T+1. Without the macro → request issued at 0x104 with be=1111.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store sequencer between execute and the data-memory bus; `LSU_MISALIGN_TRAP_EN traps misaligned half/word accesses
module lsu_mem_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              req_valid_in,
    output logic              req_ready_o,
    input  logic              is_store_in,
    input  logic [1:0]        load_size_in,
    input  logic              load_unsigned_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic [4:0]        rd_addr_in,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [3:0]        bus_be_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic              bus_ack_in,
    input  logic [DATA_W-1:0] bus_rdata_in,
    output logic              stall_o,
    output logic              wb_valid_o,
    output logic [4:0]        wb_rd_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic              err_o,
    output logic              misalign_o
);
    localparam int CW = $clog2(TIMEOUT_CYC + 2);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;
    state_t state, nxt;
    logic [CW-1:0] cnt;
    logic uns_q;
    logic [1:0] sz_q, off_q;
    logic accept, expire, mis;
    logic [3:0] be_n;
    logic [DATA_W-1:0] wd_n, ld;
    logic [7:0] lb;
    logic [15:0] lh;
    assign accept = state == IDLE && req_valid_in;
    assign expire = TIMEOUT_CYC != 0 && int'(cnt) + 1 == TIMEOUT_CYC;
    assign be_n = load_size_in == 2'b00 ? 4'b0001 << addr_in[1:0] :
                  load_size_in == 2'b01 ? 4'b0011 << {addr_in[1], 1'b0} : 4'b1111;
    assign wd_n = load_size_in == 2'b00 ? {4{wdata_in[7:0]}} :
                  load_size_in == 2'b01 ? {2{wdata_in[15:0]}} : wdata_in;
    assign lb = 8'(bus_rdata_in >> {off_q, 3'b000});
    assign lh = off_q[1] ? bus_rdata_in[31:16] : bus_rdata_in[15:0];
    assign ld = sz_q == 2'b00 ? {{24{lb[7] & ~uns_q}}, lb} :
                sz_q == 2'b01 ? {{16{lh[15] & ~uns_q}}, lh} : bus_rdata_in;
    assign bus_req_o   = state == ACCESS;
    assign stall_o     = state != IDLE;
    assign req_ready_o = state == IDLE && !rst_in;
    assign wb_valid_o  = state == RESP;
`ifdef LSU_MISALIGN_TRAP_EN
    logic mis_q;
    assign mis        = (load_size_in == 2'b01 && addr_in[0]) || (load_size_in[1] && addr_in[1:0] != 2'b00);
    assign err_o      = state == ERR && !mis_q;
    assign misalign_o = state == ERR && mis_q;
    // remember whether the ERR visit was a misalignment trap rather than a timeout
    always_ff @(posedge clk_in or posedge rst_in)
        if (rst_in) mis_q <= 1'b0;
        else if (accept) mis_q <= mis;
`else
    assign mis        = 1'b0;
    assign err_o      = state == ERR;
    assign misalign_o = 1'b0;
`endif
    // state register
    always_ff @(posedge clk_in or posedge rst_in)
        if (rst_in) state <= IDLE;
        else state <= nxt;
    // next state: ack beats a coincident timeout
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = accept ? (mis ? ERR : ACCESS) : IDLE;
            ACCESS:  nxt = bus_ack_in ? (bus_we_o ? IDLE : RESP) : (expire ? ERR : ACCESS);
            default: nxt = IDLE;
        endcase
    end
    // latch the op at acceptance, count access cycles, capture load data at ack
    always_ff @(posedge clk_in or posedge rst_in)
        if (rst_in) begin
            cnt         <= '0;
            uns_q       <= 1'b0;
            sz_q        <= 2'b00;
            off_q       <= 2'b00;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_be_o    <= 4'b0000;
            bus_wdata_o <= '0;
            wb_rd_o     <= 5'd0;
            wb_data_o   <= '0;
        end else begin
            if (accept) begin
                cnt         <= '0;
                uns_q       <= load_unsigned_in;
                sz_q        <= load_size_in;
                off_q       <= addr_in[1:0];
                bus_we_o    <= is_store_in;
                bus_addr_o  <= {addr_in[ADDR_W-1:2], 2'b00};
                bus_be_o    <= be_n;
                bus_wdata_o <= wd_n;
                wb_rd_o     <= rd_addr_in;
            end
            if (state == ACCESS) cnt <= cnt + CW'(1);
            if (state == ACCESS && bus_ack_in) wb_data_o <= ld;
        end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed scoreboard bench for lsu_mem_ctrl with a 4-cycle timeout
module tb_lsu_mem_ctrl;
    logic clk = 1'b0, rst = 1'b1;
    logic req_valid = 1'b0, is_store = 1'b0, uns = 1'b0, bus_ack = 1'b0;
    logic [1:0] size = 2'b00;
    logic [31:0] addr = '0, wdata = '0, bus_rdata = '0;
    logic [4:0] rd = '0;
    logic req_ready, bus_req, bus_we, stall, wb_valid, err, misalign;
    logic [31:0] bus_addr, bus_wdata, wb_data;
    logic [3:0] bus_be;
    logic [4:0] wb_rd;
    int checks = 0, errors = 0;
    logic [36:0] sb[$];

    lsu_mem_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(4)) dut (
        .clk_in(clk), .rst_in(rst), .req_valid_in(req_valid), .req_ready_o(req_ready),
        .is_store_in(is_store), .load_size_in(size), .load_unsigned_in(uns),
        .addr_in(addr), .wdata_in(wdata), .rd_addr_in(rd),
        .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_o(bus_addr), .bus_be_o(bus_be),
        .bus_wdata_o(bus_wdata), .bus_ack_in(bus_ack), .bus_rdata_in(bus_rdata),
        .stall_o(stall), .wb_valid_o(wb_valid), .wb_rd_o(wb_rd), .wb_data_o(wb_data),
        .err_o(err), .misalign_o(misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic st, input logic [1:0] sz, input logic un,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] r);
        req_valid = 1'b1; is_store = st; size = sz; uns = un; addr = a; wdata = wd; rd = r;
        chk("ready_before_accept", {31'd0, req_ready}, 32'd1);
        tick;
        req_valid = 1'b0; is_store = ~st; size = ~sz; uns = ~un; addr = ~a; wdata = ~wd; rd = ~r;
    endtask

    task automatic ack_after(input int n, input logic [31:0] rdat);
        repeat (n) tick;
        bus_ack = 1'b1; bus_rdata = rdat;
        tick;
        bus_ack = 1'b0; bus_rdata = $urandom;
    endtask

    // every writeback must match the oldest expected load result
    always @(negedge clk) if (wb_valid) begin
        if (sb.size() == 0) chk("unexpected_wb", {31'd0, wb_valid}, 32'd0);
        else begin
            logic [36:0] e;
            e = sb.pop_front();
            chk("sb_wb_rd", {27'd0, wb_rd}, {27'd0, e[36:32]});
            chk("sb_wb_data", wb_data, e[31:0]);
        end
    end

    initial begin
        #2;
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
        tick; rst = 1'b0; tick;
        // word load with ack coinciding with timeout expiry
        start(1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 5'd3);
        chk("wl_bus_req", {31'd0, bus_req}, 32'd1);
        chk("wl_addr", bus_addr, 32'h104);
        chk("wl_be", {28'd0, bus_be}, 32'hf);
        chk("wl_we", {31'd0, bus_we}, 32'd0);
        chk("wl_stall", {31'd0, stall}, 32'd1);
        chk("wl_ready", {31'd0, req_ready}, 32'd0);
        sb.push_back({5'd3, 32'hDEADBEEF});
        ack_after(3, 32'hDEADBEEF);
        chk("wl_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("wl_req_drop", {31'd0, bus_req}, 32'd0);
        chk("wl_stall_wb", {31'd0, stall}, 32'd1);
        chk("wl_no_err", {31'd0, err}, 32'd0);
        tick;
        chk("wl_idle_stall", {31'd0, stall}, 32'd0);
        chk("wl_wb_pulse", {31'd0, wb_valid}, 32'd0);
        // signed and unsigned byte loads from the top lane
        start(1'b0, 2'b00, 1'b0, 32'h203, 32'h0, 5'd5);
        chk("sb_be", {28'd0, bus_be}, 32'h8);
        chk("sb_addr", bus_addr, 32'h200);
        sb.push_back({5'd5, 32'hFFFFFF80});
        ack_after(1, 32'h80FFFFFF);
        chk("sb_wb_valid", {31'd0, wb_valid}, 32'd1);
        tick;
        start(1'b0, 2'b00, 1'b1, 32'h203, 32'h0, 5'd6);
        sb.push_back({5'd6, 32'h00000080});
        ack_after(0, 32'h80FFFFFF);
        tick;
        // signed half load from the upper half
        start(1'b0, 2'b01, 1'b0, 32'h502, 32'h0, 5'd7);
        chk("hl_be", {28'd0, bus_be}, 32'hc);
        sb.push_back({5'd7, 32'hFFFF9876});
        ack_after(2, 32'h98761234);
        tick;
        // half store
        start(1'b1, 2'b01, 1'b0, 32'h302, 32'h1234ABCD, 5'd9);
        chk("hs_we", {31'd0, bus_we}, 32'd1);
        chk("hs_be", {28'd0, bus_be}, 32'hc);
        chk("hs_wdata", bus_wdata, 32'hABCDABCD);
        chk("hs_addr", bus_addr, 32'h300);
        ack_after(1, 32'h0);
        chk("hs_ready", {31'd0, req_ready}, 32'd1);
        chk("hs_no_wb", {31'd0, wb_valid}, 32'd0);
        chk("hs_req_drop", {31'd0, bus_req}, 32'd0);
        // byte store lane replication
        start(1'b1, 2'b00, 1'b0, 32'h401, 32'h000000A5, 5'd0);
        chk("bs_be", {28'd0, bus_be}, 32'h2);
        chk("bs_wdata", bus_wdata, 32'hA5A5A5A5);
        ack_after(0, 32'h0);
        // timeout with no ack
        start(1'b0, 2'b10, 1'b0, 32'h600, 32'h0, 5'd1);
        for (int i = 0; i < 4; i++) begin
            chk("to_bus_req", {31'd0, bus_req}, 32'd1);
            chk("to_err_low", {31'd0, err}, 32'd0);
            tick;
        end
        chk("to_err", {31'd0, err}, 32'd1);
        chk("to_req_drop", {31'd0, bus_req}, 32'd0);
        chk("to_stall", {31'd0, stall}, 32'd1);
        chk("to_no_wb", {31'd0, wb_valid}, 32'd0);
        tick;
        chk("to_err_pulse", {31'd0, err}, 32'd0);
        start(1'b0, 2'b10, 1'b0, 32'h700, 32'h0, 5'd2);
        sb.push_back({5'd2, 32'h13579BDF});
        ack_after(0, 32'h13579BDF);
        tick;
        // reset two cycles into an access
        start(1'b0, 2'b10, 1'b0, 32'h800, 32'h0, 5'd4);
        tick; tick;
        rst = 1'b1;
        #1;
        chk("ra_bus_req", {31'd0, bus_req}, 32'd0);
        chk("ra_stall", {31'd0, stall}, 32'd0);
        chk("ra_ready", {31'd0, req_ready}, 32'd0);
        chk("ra_be", {28'd0, bus_be}, 32'h0);
        chk("ra_addr", bus_addr, 32'h0);
        chk("ra_wb", {31'd0, wb_valid}, 32'd0);
        tick;
        rst = 1'b0;
        bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
        tick;
        bus_ack = 1'b0;
        chk("ra_ack_ignored_stall", {31'd0, stall}, 32'd0);
        tick;
        chk("ra_no_wb", {31'd0, wb_valid}, 32'd0);
        chk("ra_no_err", {31'd0, err}, 32'd0);
        // misaligned word load
        start(1'b0, 2'b10, 1'b0, 32'h106, 32'h0, 5'd8);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("ma_misalign", {31'd0, misalign}, 32'd1);
        chk("ma_no_req", {31'd0, bus_req}, 32'd0);
        chk("ma_no_err", {31'd0, err}, 32'd0);
        chk("ma_stall", {31'd0, stall}, 32'd1);
        tick;
        chk("ma_idle", {31'd0, req_ready}, 32'd1);
        chk("ma_pulse", {31'd0, misalign}, 32'd0);
`else
        chk("ma_misalign", {31'd0, misalign}, 32'd0);
        chk("ma_req", {31'd0, bus_req}, 32'd1);
        chk("ma_addr", bus_addr, 32'h104);
        chk("ma_be", {28'd0, bus_be}, 32'hf);
        sb.push_back({5'd8, 32'h2468ACE0});
        ack_after(0, 32'h2468ACE0);
        tick;
`endif
        tick;
        chk("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
